// File: rtl/waveform_pkg.sv
// Shared definitions for the NeoPixel waveform generator / decoder pair.
`timescale 1ns/1ps
package waveform_pkg;

    // Decoder line states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // High-pulse counter width (saturates at all-ones)
    localparam int HCNT_W     = 8;
    // Default low-period counter / reset-gap threshold width
    localparam int LCNT_W_DEF = 16;
    // Width of the min/threshold timing registers, shared with waveform_gen
    localparam int TREG_W     = 8;
    // Width of the per-frame decoded bit counter
    localparam int BCNT_W     = 16;

endpackage

// File: rtl/line_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
`timescale 1ns/1ps
module line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_sync;

    // Shift the raw input through the flop chain; last stage is the clean sample
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/waveform_dec.sv
// NRZ pulse-width line decoder: measures high pulses, classifies them as
// 0/1 bits, flags glitches and over-long pulses, and detects reset gaps.
`timescale 1ns/1ps
module waveform_dec
    import waveform_pkg::*;
#(
    parameter int LCNT_W      = LCNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              bit_code_i,
    input  logic [TREG_W-1:0] reg_min_time_i,
    input  logic [TREG_W-1:0] reg_thr_time_i,
    input  logic [LCNT_W-1:0] reg_rst_time_i,
    output logic              bit_vld_o,
    output logic              bit_data_o,
    output logic              frame_end_o,
    output logic              err_o,
    output logic [BCNT_W-1:0] bit_cnt_o
);

    logic              w_line_s;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HCNT_W-1:0] r_hcnt;
    logic [HCNT_W-1:0] w_hcnt_nxt;
    logic [LCNT_W-1:0] r_lcnt;
    logic [LCNT_W-1:0] w_lcnt_nxt;
    logic [LCNT_W-1:0] w_lcnt_inc;
    logic              r_bit_vld;
    logic              w_bit_vld_nxt;
    logic              r_bit_data;
    logic              w_bit_data_nxt;
    logic              r_frame_end;
    logic              w_frame_end_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [BCNT_W-1:0] r_bit_cnt;
    logic [BCNT_W-1:0] w_bit_cnt_nxt;

    line_sync #(
        .STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (bit_code_i),
        .q_o     (w_line_s)
    );

    // State, counters and registered strobes
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_hcnt      <= '0;
            r_lcnt      <= '0;
            r_bit_vld   <= 1'b0;
            r_bit_data  <= 1'b0;
            r_frame_end <= 1'b0;
            r_err       <= 1'b0;
            r_bit_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_lcnt      <= w_lcnt_nxt;
            r_bit_vld   <= w_bit_vld_nxt;
            r_bit_data  <= w_bit_data_nxt;
            r_frame_end <= w_frame_end_nxt;
            r_err       <= w_err_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
        end
    end

    // Next-state logic; a rising edge in LOW wins over a same-cycle frame end
    always_comb begin
        w_state_nxt     = r_state;
        w_hcnt_nxt      = r_hcnt;
        w_lcnt_nxt      = r_lcnt;
        w_bit_vld_nxt   = 1'b0;
        w_bit_data_nxt  = r_bit_data;
        w_frame_end_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_lcnt_inc      = (&r_lcnt) ? r_lcnt : r_lcnt + 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_line_s) begin
                    w_state_nxt = ST_HIGH;
                    w_hcnt_nxt  = HCNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (w_line_s) begin
                    w_hcnt_nxt = (&r_hcnt) ? r_hcnt : r_hcnt + 1'b1;
                end else begin
                    w_state_nxt = ST_LOW;
                    w_lcnt_nxt  = LCNT_W'(1);
                    if (&r_hcnt) begin
                        w_err_nxt = 1'b1;
                    end else if (r_hcnt <= reg_min_time_i) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_bit_vld_nxt  = 1'b1;
                        w_bit_data_nxt = (r_hcnt > reg_thr_time_i);
                        w_bit_cnt_nxt  = (&r_bit_cnt) ? r_bit_cnt : r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (w_line_s) begin
                    w_state_nxt = ST_HIGH;
                    w_hcnt_nxt  = HCNT_W'(1);
                end else begin
                    w_lcnt_nxt = w_lcnt_inc;
                    if ((reg_rst_time_i != '0) && (w_lcnt_inc == reg_rst_time_i)) begin
                        w_frame_end_nxt = 1'b1;
                        w_bit_cnt_nxt   = '0;
                        w_state_nxt     = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bit_vld_o   = r_bit_vld;
    assign bit_data_o  = r_bit_data;
    assign frame_end_o = r_frame_end;
    assign err_o       = r_err;
    assign bit_cnt_o   = r_bit_cnt;

endmodule

// File: doc/waveform_dec.md
Name: waveform_dec

Overview:
Receive-side counterpart of the NeoPixel waveform generator. Samples a single-wire NRZ pulse-width line, measures each high pulse in clock cycles and classifies it as a 0 or 1 bit. Detects the inter-frame reset (long low) gap and flags malformed pulses. Used for loop-back self-test of the LED output path and for daisy-chain input capture.

Parameters:
LCNT_W, 16, width of low-period counter and reset-gap threshold.
SYNC_STAGES, 2, input synchronizer depth (minimum 2).

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
bit_code_i  in  1  raw serial line (asynchronous to clk_i)
reg_min_time_i  in  8  high pulses with hcnt <= this value are glitches
reg_thr_time_i  in  8  bit threshold: hcnt > value decodes as 1, otherwise 0
reg_rst_time_i  in  LCNT_W  low cycles that end a frame; 0 disables frame detection
bit_vld_o  out  1  one-cycle strobe, decoded bit valid
bit_data_o  out  1  decoded bit value, held until next strobe
frame_end_o  out  1  one-cycle strobe on reset-gap detection
err_o  out  1  one-cycle strobe on glitch or over-long high pulse
bit_cnt_o  out  16  bits decoded in current frame, saturating

Behaviour:
- Reset (async assert, sync release): all outputs 0, synchronizer flops 0, hcnt=0, lcnt=0, state IDLE.
- Synchronizer: SYNC_STAGES flops. line_s is the last stage. All decode logic uses only line_s.
- hcnt is 8 bit and saturates at 8'hFF. lcnt is LCNT_W bit and saturates at all-ones.
- States: IDLE, HIGH, LOW.
  - IDLE: line_s=1 -> HIGH, hcnt<=1. Otherwise stay. lcnt is not counted.
  - HIGH: line_s=1 -> hcnt saturating increment.
  - HIGH, line_s=0 (falling edge): evaluate hcnt, then -> LOW, lcnt<=1.
    - hcnt==8'hFF -> err_o strobe, no bit.
    - else hcnt<=reg_min_time_i -> err_o strobe, no bit.
    - else bit_vld_o strobe; bit_data_o <= (hcnt > reg_thr_time_i); bit_cnt_o saturating increment.
  - LOW: line_s=1 -> HIGH, hcnt<=1. A rising edge takes priority over frame end in the same cycle.
  - LOW: line_s=0 -> lcnt saturating increment. When the incremented value equals reg_rst_time_i and reg_rst_time_i!=0: frame_end_o strobe, bit_cnt_o<=0, -> IDLE.
- Latency:
  - bit_vld_o/err_o are registered and asserted the cycle after the first line_s=0 sample.
  - That is SYNC_STAGES+1 clocks after the line falls, as sampled at a clock edge.
- Strobe exclusivity: bit_vld_o and err_o are never high together. frame_end_o cannot coincide with either, because it needs at least one LOW cycle after the falling edge.
- bit_data_o keeps its last value while bit_vld_o=0.
- Register inputs are sampled live with no shadowing. A change mid-pulse affects that pulse's evaluation.
- reg_min_time_i >= reg_thr_time_i makes every valid pulse a 1. This is legal and not flagged.
- A line high at reset release enters HIGH and is measured normally.
- Reset asserted mid-pulse aborts it: no strobe, and all state is cleared immediately.

Decomposition:
- Shared package waveform_pkg:
  - state enum (IDLE/HIGH/LOW)
  - HCNT_W=8 and default LCNT_W
  - timing-register width constants, shared with waveform_gen
- One sub-module, line_sync: parameterized SYNC_STAGES flop chain with async active-low reset. It is reused by other asynchronous inputs.

Test Plan:
Common setup for all scenarios: clk 200 MHz, SYNC_STAGES=2, min=0, thr=2, rst=10.
1. High 2 cycles then low 3 cycles, then high 3 cycles then low 12 cycles.
   -> bit_vld_o pulses twice with data 0 then 1. Each strobe comes 3 clocks after its falling edge.
   -> frame_end_o pulses once, 10 low cycles after the second fall; bit_cnt_o goes 1, 2, then 0.
2. min=1, high 1 cycle.
   -> err_o strobe, no bit_vld_o, bit_cnt_o unchanged, bit_data_o holds its previous value.
3. High for 300 cycles then low.
   -> hcnt saturates at 8'hFF; err_o strobe at the fall, no bit.
4. Low gap of exactly 9 cycles then a rising edge, repeated.
   -> no frame_end_o. With a 10-cycle gap where the rising edge lands in the lcnt==10 cycle: no frame_end_o, since the edge wins.
5. rst=0, low 1000 cycles.
   -> frame_end_o never asserts.
6. rst_n_i asserted during a 3-cycle high pulse, released, then a 3-cycle pulse sent.
   -> no strobe for the aborted pulse; all outputs 0 during reset.
   -> the second pulse decodes as 1 with bit_cnt_o=1.
